// File: rtl/bcd_code_pkg.sv
// Shared constants and types for the multi-digit 8421 <-> 5421 BCD converter.
package bcd_code_pkg;

    localparam int DIGIT_W = 4;

    localparam logic MODE_8421_TO_5421 = 1'b0;
    localparam logic MODE_5421_TO_8421 = 1'b1;

    localparam logic [DIGIT_W-1:0] BCD_INVALID_OUT = 4'h0;
    localparam logic [DIGIT_W-1:0] BCD_MAX_8421    = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_5421    = 4'd12;
    localparam logic [DIGIT_W-1:0] BCD_FIVE_5421   = 4'd8;
    localparam logic [DIGIT_W-1:0] BCD_LOW_MAX     = 4'd4;
    localparam logic [DIGIT_W-1:0] BCD_5421_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    // Step counter width; a single-step word still needs a 1-bit counter.
    function automatic int step_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/bcd_code_conv_seq_digit.sv
// Combinational single-digit 8421 <-> 5421 converter with invalid-code detection.
module bcd_digit_conv
    import bcd_code_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] code,
    output logic       err
);

    // Codes 0..4 are identical in both weightings; only the upper half moves by 3.
    function automatic logic [4:0] map_to_5421(input logic [3:0] d);
        if (d <= BCD_LOW_MAX)
            return {1'b0, d};
        else if (d <= BCD_MAX_8421)
            return {1'b0, d + BCD_5421_OFFSET};
        else
            return {1'b1, BCD_INVALID_OUT};
    endfunction

    function automatic logic [4:0] map_to_8421(input logic [3:0] d);
        if (d <= BCD_LOW_MAX)
            return {1'b0, d};
        else if (d >= BCD_FIVE_5421 && d <= BCD_MAX_5421)
            return {1'b0, d - BCD_5421_OFFSET};
        else
            return {1'b1, BCD_INVALID_OUT};
    endfunction

    logic [4:0] mapped;

    always_comb begin
        mapped = {1'b1, BCD_INVALID_OUT};
        if (mode == MODE_8421_TO_5421)
            mapped = map_to_5421(digit);
        else
            mapped = map_to_8421(digit);
    end

    assign err  = mapped[4];
    assign code = mapped[3:0];

endmodule

// File: rtl/bcd_code_conv_seq.sv
// Sequential NDIG-digit 8421 <-> 5421 converter, LANES digits per cycle, LSD first,
// with valid/ready handshakes on both sides and per-digit invalid-code flags.
module bcd_code_conv_seq
    import bcd_code_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [4*NDIG-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_data,
    output logic [NDIG-1:0]   out_err,
    output logic              out_err_any
);

    localparam int NSTEP = (LANES > 0) ? (NDIG / LANES) : 1;
    localparam int CW    = step_cnt_w(NSTEP);
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    generate
        if (NDIG < 1 || LANES < 1 || ((LANES > 0) ? (NDIG % LANES) : 1) != 0) begin : g_bad_cfg
            $error("bcd_code_conv_seq: NDIG must be >= 1 and a multiple of LANES");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic              accept;

    logic              mode_p0;
    logic [4*NDIG-1:0] src_p0;
    logic [4*NDIG-1:0] res_p1;
    logic [NDIG-1:0]   err_p1;

    logic [3:0]        lane_digit [LANES];
    logic [3:0]        lane_code  [LANES];
    logic [LANES-1:0]  lane_err;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST_STEP)
                    state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                // Same-edge handoff lets a waiting word start as the result leaves.
                in_ready  = out_ready;
                if (out_ready)
                    state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Stage p0: operand capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            src_p0  <= in_data;
            mode_p0 <= in_mode;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_digit[l] = src_p0[4*l +: 4];
            for (int s = 0; s < NSTEP; s++) begin
                if (cnt == CW'(s))
                    lane_digit[l] = src_p0[4*(s*LANES + l) +: 4];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bcd_digit_conv u_conv (
            .digit (lane_digit[l]),
            .mode  (mode_p0),
            .code  (lane_code[l]),
            .err   (lane_err[l])
        );
    end

    // Stage p1: per-step result/error write-back and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            res_p1 <= '0;
            err_p1 <= '0;
        end else if (accept) begin
            cnt    <= '0;
            res_p1 <= '0;
            err_p1 <= '0;
        end else if (state == RUN) begin
            if (cnt != LAST_STEP)
                cnt <= cnt + CW'(1);
            for (int k = 0; k < NDIG; k++) begin
                if (cnt == CW'(k / LANES)) begin
                    res_p1[4*k +: 4] <= lane_code[k % LANES];
                    err_p1[k]        <= lane_err[k % LANES];
                end
            end
        end
    end

    assign out_data    = res_p1;
    assign out_err     = err_p1;
    assign out_err_any = |err_p1;

endmodule

// File: tb/tb_bcd_code_conv_seq.sv
// Self-checking bench for bcd_code_conv_seq: LANES=1 main instance plus LANES=2/4 latency instances.
`timescale 1ns/1ps
module tb_bcd_code_conv_seq;

    localparam int NDIG = 4;
    localparam int W    = 4*NDIG;

    typedef struct packed {
        logic [W-1:0]    data;
        logic [NDIG-1:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_mode;
    logic out_ready;
    logic [W-1:0] in_data;
    logic valid1, valid2, valid4;
    logic ready1, ready2, ready4;
    logic ovalid1, ovalid2, ovalid4;
    logic any1, any2, any4;
    logic [W-1:0] odata1, odata2, odata4;
    logic [NDIG-1:0] oerr1, oerr2, oerr4;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    bcd_code_conv_seq #(.NDIG(NDIG), .LANES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(valid1), .in_ready(ready1), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ovalid1), .out_ready(out_ready), .out_data(odata1),
        .out_err(oerr1), .out_err_any(any1));

    bcd_code_conv_seq #(.NDIG(NDIG), .LANES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(valid2), .in_ready(ready2), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ovalid2), .out_ready(out_ready), .out_data(odata2),
        .out_err(oerr2), .out_err_any(any2));

    bcd_code_conv_seq #(.NDIG(NDIG), .LANES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(valid4), .in_ready(ready4), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ovalid4), .out_ready(out_ready), .out_data(odata4),
        .out_err(oerr4), .out_err_any(any4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enc5421(input int v);
        return (v < 5) ? 4'(v) : 4'(v + 3);
    endfunction

    // Reference: search the ten legal values for a match instead of range arithmetic.
    function automatic exp_t model_word(input logic [W-1:0] w, input logic m);
        exp_t r;
        logic [3:0] dig;
        logic hit;
        r.data = '0;
        r.err  = '0;
        for (int k = 0; k < NDIG; k++) begin
            dig = w[4*k +: 4];
            hit = 1'b0;
            for (int v = 0; v < 10; v++) begin
                if (m == 1'b0 && dig == 4'(v)) begin
                    r.data[4*k +: 4] = enc5421(v);
                    hit = 1'b1;
                end
                if (m == 1'b1 && dig == enc5421(v)) begin
                    r.data[4*k +: 4] = 4'(v);
                    hit = 1'b1;
                end
            end
            r.err[k] = !hit;
        end
        return r;
    endfunction

    task automatic push_const(input logic [W-1:0] d, input logic [NDIG-1:0] e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sbq.push_back(x);
    endtask

    task automatic drive_word(input logic [W-1:0] w, input logic m);
        int n;
        in_data = w;
        in_mode = m;
        valid1  = 1'b1;
        n = 0;
        while (ready1 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", ready1);
        end
        tick();
        valid1 = 1'b0;
    endtask

    task automatic recv_word(input int exp_lat);
        int n;
        exp_t e;
        n = 0;
        while (ovalid1 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ovalid1 !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout out_valid=%b required 1", ovalid1);
        end else begin
            if (exp_lat > 0) begin
                checks++;
                if (n != exp_lat) begin
                    errors++;
                    $display("FAIL latency got %0d required %0d", n, exp_lat);
                end
            end
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty unexpected result %h", odata1);
            end else begin
                e = sbq.pop_front();
                if (odata1 !== e.data) begin
                    errors++;
                    $display("FAIL out_data got %h required %h", odata1, e.data);
                end
                checks++;
                if (oerr1 !== e.err) begin
                    errors++;
                    $display("FAIL out_err got %b required %b", oerr1, e.err);
                end
                checks++;
                if (any1 !== (|e.err)) begin
                    errors++;
                    $display("FAIL out_err_any got %b required %b", any1, |e.err);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ovalid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", ovalid1); end
        checks++;
        if (odata1 !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", odata1); end
        checks++;
        if (oerr1 !== '0 || any1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_err got %b/%b required 0000/0", oerr1, any1);
        end
        checks++;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", ready1); end
    endtask

    task automatic test_basic();
        push_const(16'h1C3A, 4'b0000);
        drive_word(16'h1937, 1'b0);
        recv_word(4);
        push_const(16'h1937, 4'b0000);
        drive_word(16'h1C3A, 1'b1);
        recv_word(4);
    endtask

    task automatic test_invalid();
        push_const(16'h1204, 4'b0010);
        drive_word(16'h12A4, 1'b0);
        recv_word(4);
        push_const(16'h0000, 4'b0101);
        drive_word(16'h0506, 1'b1);
        recv_word(4);
    endtask

    task automatic lane_case(input int sel, input logic [W-1:0] w, input logic m,
                             input logic [W-1:0] exp_d, input int exp_lat);
        int n;
        logic rdy, ov, an;
        logic [W-1:0] od;
        logic [NDIG-1:0] oe;
        in_data = w;
        in_mode = m;
        if (sel == 2) valid2 = 1'b1; else valid4 = 1'b1;
        rdy = (sel == 2) ? ready2 : ready4;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL lanes%0d_in_ready got %b required 1", sel, rdy); end
        tick();
        valid2 = 1'b0;
        valid4 = 1'b0;
        n = 0;
        ov = (sel == 2) ? ovalid2 : ovalid4;
        while (ov !== 1'b1 && n < 20) begin
            tick();
            n++;
            ov = (sel == 2) ? ovalid2 : ovalid4;
        end
        od = (sel == 2) ? odata2 : odata4;
        oe = (sel == 2) ? oerr2 : oerr4;
        an = (sel == 2) ? any2 : any4;
        checks++;
        if (ov !== 1'b1 || n != exp_lat) begin
            errors++;
            $display("FAIL lanes%0d_latency got %0d (valid %b) required %0d", sel, n, ov, exp_lat);
        end
        checks++;
        if (od !== exp_d) begin errors++; $display("FAIL lanes%0d_data got %h required %h", sel, od, exp_d); end
        checks++;
        if (oe !== '0 || an !== 1'b0) begin
            errors++;
            $display("FAIL lanes%0d_err got %b/%b required 0000/0", sel, oe, an);
        end
        tick();
    endtask

    task automatic test_lanes();
        lane_case(2, 16'h1937, 1'b0, 16'h1C3A, 2);
        lane_case(2, 16'h1C3A, 1'b1, 16'h1937, 2);
        lane_case(4, 16'h1937, 1'b0, 16'h1C3A, 1);
        lane_case(4, 16'h1C3A, 1'b1, 16'h1937, 1);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        drive_word(16'h1937, 1'b0);
        n = 0;
        while (ovalid1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ovalid1 !== 1'b1 || odata1 !== 16'h1C3A || oerr1 !== 4'b0000 || any1 !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d valid %b data %h err %b required 1 1c3a 0000", c, ovalid1, odata1, oerr1);
            end
            checks++;
            if (ready1 !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b required 0", ready1); end
            tick();
        end
        push_const(16'h000C, 4'b0000);
        in_data   = 16'h0009;
        in_mode   = 1'b0;
        valid1    = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL bypass_in_ready got %b required 1", ready1); end
        tick();
        valid1 = 1'b0;
        checks++;
        if (ovalid1 !== 1'b0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_accept valid %b ready %b required 0 0", ovalid1, ready1);
        end
        recv_word(4);
    endtask

    task automatic test_reset_mid();
        drive_word(16'h1937, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ovalid1 !== 1'b0 || odata1 !== '0 || oerr1 !== '0 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset valid %b data %h err %b ready %b required 0 0000 0000 1", ovalid1, odata1, oerr1, ready1);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (ovalid1 !== 1'b0) begin errors++; $display("FAIL discarded_word out_valid cyc %0d got 1 required 0", c); end
            tick();
        end
        push_const(16'h4321, 4'b0000);
        drive_word(16'h4321, 1'b0);
        recv_word(4);
    endtask

    task automatic test_back_to_back();
        int total;
        int got;
        int cyc;
        exp_t e;
        logic [W-1:0] w;
        total = 32;
        got   = 0;
        fork
            begin
                for (int m = 0; m < 2; m++) begin
                    for (int c = 0; c < 16; c++) begin
                        for (int k = 0; k < NDIG; k++) w[4*k +: 4] = 4'((c + 5*k) % 16);
                        sbq.push_back(model_word(w, 1'(m)));
                        drive_word(w, 1'(m));
                    end
                end
            end
            begin
                cyc = 0;
                while (got < total && cyc < 1000) begin
                    tick();
                    cyc++;
                    if (ovalid1 === 1'b1) begin
                        got++;
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_scoreboard_empty result %h", odata1);
                        end else begin
                            e = sbq.pop_front();
                            if (odata1 !== e.data || oerr1 !== e.err || any1 !== (|e.err)) begin
                                errors++;
                                $display("FAIL b2b_word %0d got %h/%b/%b required %h/%b/%b", got, odata1, oerr1, any1, e.data, e.err, |e.err);
                            end
                        end
                    end
                end
                checks++;
                if (got != total) begin
                    errors++;
                    $display("FAIL b2b_count got %0d required %0d", got, total);
                end
            end
        join
    endtask

    initial begin
        rst       = 1'b1;
        valid1    = 1'b0;
        valid2    = 1'b0;
        valid4    = 1'b0;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        in_data   = '0;
        test_reset();
        test_basic();
        test_invalid();
        test_lanes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_code_conv_seq.md
Name: bcd_code_conv_seq

Overview:
- Multi-digit, bidirectional BCD code converter: 8421 to 5421 (mode 0) or 5421 to 8421 (mode 1).
- Accepts an NDIG-digit word on a valid/ready handshake and converts LANES digits per cycle, LSD first.
- Presents the result word with per-digit invalid-code flags on a second valid/ready handshake.
- Sits between the operand registers and the 5421-based partial-product generator of the decimal multiplier, replacing the single-digit combinational converter.

Parameters:
- NDIG, 4, number of BCD digits per word; must be at least 1.
- LANES, 1, digits converted per cycle; must satisfy NDIG % LANES == 0 (elaboration-time assertion).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_mode  in  1  0 = 8421 to 5421, 1 = 5421 to 8421; sampled with the word.
- in_data  in  4*NDIG  digits, digit k = bits [4k+3:4k].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  4*NDIG  converted digits.
- out_err  out  NDIG  bit k set = input digit k was an invalid code.
- out_err_any  out  1  OR of out_err.

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, digit counter 0, out_valid=0, out_data=0, out_err=0, out_err_any=0. in_ready is combinational and is 1 after reset.
- FSM states IDLE, RUN, HOLD.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch in_data and in_mode;
  - clear the result and error registers;
  - set counter=0 and go to RUN.
- RUN: in_ready=0.
  - Each cycle converts digits [counter*LANES .. counter*LANES+LANES-1] into the result/error registers, then counter += 1.
  - After NDIG/LANES RUN cycles, go to HOLD.
  - out_valid rises exactly NDIG/LANES cycles after the accepting edge (NDIG=4, LANES=1: 4 cycles; LANES=4: 1 cycle).
- HOLD: out_valid=1.
  - out_data, out_err and out_err_any are stable and must not change while out_valid=1 and out_ready=0.
  - in_ready = out_ready, a combinational bypass.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 and in_valid=1: the new word is accepted on the same edge and the block goes to RUN. This gives back-to-back throughput of one word per NDIG/LANES+1 cycles.
- out_valid is never asserted in IDLE or RUN. in_valid is ignored in RUN.
- Digit map, mode 0: 8421 values 0..4 map to 0000..0100 (same code); 5..9 map to 1000..1100 (value+3).
  - Inputs 1010..1111 are invalid: output digit forced to 0000, error bit set.
- Digit map, mode 1: 5421 codes 0000..0100 map to 0..4; 1000..1100 map to 5..9 (code-3).
  - Codes 0101, 0110, 0111, 1101, 1110, 1111 are invalid: output 0000, error bit set.
- An invalid digit never stalls or aborts conversion. Remaining digits convert normally.
- Reset mid-operation (RUN or HOLD): the word in flight is discarded, no out_valid is produced, and the block is in IDLE next cycle.
- The counter width is clog2(NDIG/LANES) with a minimum of 1 bit. The counter never wraps inside one word; it is reloaded to 0 on every accept.

Decomposition:
- Package bcd_code_pkg:
  - mode constants MODE_8421_TO_5421=1'b0 and MODE_5421_TO_8421=1'b1;
  - state enum {IDLE, RUN, HOLD};
  - digit-code constants (BCD_INVALID_OUT=4'h0).
- Sub-module bcd_digit_conv: purely combinational single-digit converter with inputs digit[3:0] and mode, outputs code[3:0] and err. It is instantiated LANES times, and the lane inputs are muxed by the counter.

Test Plan:
- NDIG=4, LANES=1, mode 0, in_data=0x1937: out_data=0x1C3A, out_err=0000, out_valid exactly 4 cycles after the accept edge.
- Same configuration, mode 1, in_data=0x1C3A: out_data=0x1937, out_err=0. Repeat with LANES=2 (2-cycle latency) and LANES=4 (1 cycle).
- Invalid codes:
  - mode 0, in_data=0x12A4: out_data=0x1204, out_err=0010, out_err_any=1.
  - mode 1, in_data=0x0506: out_data=0x0000, out_err=0101.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD. Outputs stay stable and in_ready=0. Then raise out_ready with in_valid=1 and in_data=0x0009 (mode 0): the second word is accepted on the same edge, and the next result is 0x000C.
- Reset: assert rst in the 2nd RUN cycle. Next cycle state is IDLE, out_valid=0, out_data=0, in_ready=1. A following word 0x4321 (mode 0) converts to 0x4321 with no stale error bits.
- Exhaustive: every 4-bit code in both modes on each digit position. Outputs and flags must match the digit map above, checked by a scoreboard model.
